// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I core: FSM states, opcodes, mux selects, ALU controls.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: none.
package riscv_pkg;

  // Controller FSM states
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  // Opcodes
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  // ALU control
  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Datapath mux selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Immediate format implied by the opcode; unknown opcodes fall back to I
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: imm_sel = IMM_I;
      OP_SW:       imm_sel = IMM_S;
      OP_BEQ:      imm_sel = IMM_B;
      OP_JAL:      imm_sel = IMM_J;
      OP_LUI:      imm_sel = IMM_U;
      default:     imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU operation class plus funct fields to an ALU control code.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  // Fixed classes pass straight through; the funct class decodes funct3 (sub only for R-type)
  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (aluop)
      ALUOP_ADD:  alucontrol = ALU_ADD;
      ALUOP_SUB:  alucontrol = ALU_SUB;
      ALUOP_PASS: alucontrol = ALU_PASSB;
      default: begin
        case (funct3)
          3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: begin
            alucontrol = ALU_ADD;
            illegal    = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing RV32I instructions through fetch/decode/execute/memory/writeback.
// Latency: lw 5, sw/R/I/lui/jal 4, beq 3, illegal 2 cycles; outputs combinational from state.
// Backpressure: none; every state advances each cycle, reset low forces all outputs to 0.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  logic [3:0] state, state_nxt;
  logic [1:0] aluop, srca, srcb, rsrc;
  logic       adr, irw, regw, memw, pcupdate, branch, ill_op, ill_funct;
  logic [2:0] alu_ctl;

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  // Per-state control outputs and next-state selection
  always_comb begin
    state_nxt = S_FETCH;
    aluop     = ALUOP_ADD;
    srca      = SRCA_PC;
    srcb      = SRCB_RD2;
    rsrc      = RES_ALUOUT;
    adr       = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    ill_op    = 1'b0;
    case (state)
      S_FETCH: begin
        irw       = 1'b1;
        srcb      = SRCB_FOUR;
        rsrc      = RES_ALURES;
        pcupdate  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // ALU computes the branch target from OldPC + imm while decoding
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I, OP_LUI: state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            state_nxt = S_FETCH;
            ill_op    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        srca      = SRCA_RD1;
        srcb      = SRCB_IMM;
        state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr       = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        rsrc      = RES_DATA;
        regw      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        adr       = 1'b1;
        memw      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXECUTER: begin
        srca      = SRCA_RD1;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        srca      = SRCA_RD1;
        srcb      = SRCB_IMM;
        aluop     = (op == OP_LUI) ? ALUOP_PASS : ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regw      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        srca      = SRCA_RD1;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        // Link value OldPC + 4 goes to ALUOut; PC takes the target computed in DECODE
        srca      = SRCA_OLDPC;
        srcb      = SRCB_FOUR;
        pcupdate  = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .opb5       (op[5]),
    .alucontrol (alu_ctl),
    .illegal    (ill_funct)
  );

  // Every output is held at zero while reset is asserted
  assign immsrc     = reset_n ? imm_sel(op) : 3'b000;
  assign alusrca    = reset_n ? srca : 2'b00;
  assign alusrcb    = reset_n ? srcb : 2'b00;
  assign resultsrc  = reset_n ? rsrc : 2'b00;
  assign adrsrc     = reset_n & adr;
  assign alucontrol = reset_n ? alu_ctl : 3'b000;
  assign irwrite    = reset_n & irw;
  assign pcwrite    = reset_n & (pcupdate | (branch & zero));
  assign regwrite   = reset_n & regw;
  assign memwrite   = reset_n & memw;
  assign illegal    = reset_n & (ill_op | ill_funct);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: expected per-cycle output vectors are queued per instruction and popped as the DUT steps.
// Latency: checks each cycle at negedge+1.
// Backpressure: none.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [2:0] immsrc;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite, illegal;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs;

  // Bench-side state names
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7, AW = 8, BQ = 9, JL = 10;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .immsrc     (immsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .adrsrc     (adrsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                irwrite, pcwrite, regwrite, memwrite, illegal};

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (imm|A|B|res|adr|aluctl|ir pc rw mw ill)", tag, got, want);
    end
  endtask

  // Expected outputs for one state, derived from the control table
  function automatic logic [17:0] ev(input int st, input logic [6:0] o, input logic [2:0] f3,
                                     input logic f7, input logic z);
    logic [2:0] imm, ac;
    logic [1:0] a, b, rs, aop;
    logic ad, irw, pcw, rw, mw, ill;
    a = 0; b = 0; rs = 0; aop = 0; ad = 0; irw = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
    case (o)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111: imm = 3'b100;
      default:    imm = 3'b000;
    endcase
    case (st)
      F:   begin irw = 1; b = 2; rs = 2; pcw = 1; end
      D:   begin
             a = 1; b = 1;
             ill = !(o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
                     o == 7'b0110111 || o == 7'b1100011 || o == 7'b1101111);
           end
      MA:  begin a = 2; b = 1; end
      MR:  begin ad = 1; end
      MWB: begin rs = 1; rw = 1; end
      MW:  begin ad = 1; mw = 1; end
      ER:  begin a = 2; aop = 2; end
      EI:  begin a = 2; b = 1; aop = (o == 7'b0110111) ? 2'd3 : 2'd2; end
      AW:  begin rw = 1; end
      BQ:  begin a = 2; aop = 1; pcw = z; end
      JL:  begin a = 1; b = 2; pcw = 1; end
      default: ;
    endcase
    case (aop)
      2'd0: ac = 3'b010;
      2'd1: ac = 3'b110;
      2'd3: ac = 3'b011;
      default: begin
        case (f3)
          3'b000:  ac = (o[5] && f7) ? 3'b110 : 3'b010;
          3'b010:  ac = 3'b111;
          3'b110:  ac = 3'b001;
          3'b111:  ac = 3'b000;
          default: begin ac = 3'b010; ill = 1; end
        endcase
      end
    endcase
    return {imm, a, b, rs, ad, ac, irw, pcw, rw, mw, ill};
  endfunction

  // Drive one instruction starting in FETCH; compare up to ncyc cycles (0 = whole instruction)
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int ncyc);
    int seq[$];
    int lim;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    seq = '{F, D};
    case (o)
      7'b0000011: begin seq.push_back(MA); seq.push_back(MR); seq.push_back(MWB); end
      7'b0100011: begin seq.push_back(MA); seq.push_back(MW); end
      7'b0110011: begin seq.push_back(ER); seq.push_back(AW); end
      7'b0010011,
      7'b0110111: begin seq.push_back(EI); seq.push_back(AW); end
      7'b1100011: seq.push_back(BQ);
      7'b1101111: begin seq.push_back(JL); seq.push_back(AW); end
      default: ;
    endcase
    foreach (seq[i]) exp_q.push_back(ev(seq[i], o, f3, f7, z));
    lim = (ncyc == 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < lim; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("%s c%0d", name, i + 1), obs, exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset", obs, 18'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("r_sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    @(negedge clk); run_instr("r_add",    7'b0110011, 3'b000, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("r_and",    7'b0110011, 3'b111, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("r_slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("r_or",     7'b0110011, 3'b110, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("r_bad_f3", 7'b0110011, 3'b001, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, 0);
    @(negedge clk); run_instr("beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    @(negedge clk); run_instr("beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("lui",      7'b0110111, 3'b101, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("illegal",  7'b1111111, 3'b000, 1'b0, 1'b0, 0);
    @(negedge clk); run_instr("after_ill", 7'b0010011, 3'b110, 1'b0, 1'b0, 0);

    // Reset in the middle of MEMREAD, then a full lw after release
    @(negedge clk); run_instr("lw_cut", 7'b0000011, 3'b010, 1'b0, 1'b0, 4);
    reset_n = 1'b0;
    #1 check("mid_reset", obs, 18'd0);
    @(negedge clk);
    #1 check("held_reset", obs, 18'd0);
    reset_n = 1'b1;
    run_instr("lw_post_rst", 7'b0000011, 3'b010, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core: the producer side of the ALU interface, generating `alucontrol` and the datapath mux selects/write enables, and consuming the ALU `zero` flag. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. Instantiated in the multicycle top next to the datapath and shared memory.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: async active-low reset.
- `op` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `immsrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `alusrca` out 2: 00 PC, 01 OldPC, 10 RD1.
- `alusrcb` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `resultsrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `adrsrc` out 1: 0 PC, 1 Result.
- `alucontrol` out 3: 000 and, 001 or, 010 add, 110 sub, 111 slt, 011 pass SrcB.
- `irwrite`, `pcwrite`, `regwrite`, `memwrite` out 1 each: write enables.
- `illegal` out 1: one-cycle pulse on unsupported opcode/funct.

## Operation
- State register reset value FETCH. While `reset_n` low: `irwrite`, `pcwrite`, `regwrite`, `memwrite`, `illegal` forced 0; all other outputs 0.
- Per-state outputs; unlisted signals are 0. `aluop`: 00 add, 01 sub, 10 funct-decoded, 11 pass.
  - FETCH: adrsrc 0, irwrite, A=00, B=10, aluop 00, resultsrc 10, pcupdate. Next: DECODE.
  - DECODE: A=01, B=01, aluop 00 (branch target). Next by op: 0000011/0100011 → MEMADR; 0110011 → EXECUTER; 0010011, 0110111 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; else FETCH with `illegal`.
  - MEMADR: A=10, B=01, aluop 00. Next: MEMREAD (lw) / MEMWRITE (sw).
  - MEMREAD: resultsrc 00, adrsrc 1 → MEMWB.
  - MEMWB: resultsrc 01, regwrite → FETCH.
  - MEMWRITE: resultsrc 00, adrsrc 1, memwrite → FETCH.
  - EXECUTER: A=10, B=00, aluop 10 → ALUWB.
  - EXECUTEI: A=10, B=01, aluop 10 (11 for LUI) → ALUWB.
  - ALUWB: resultsrc 00, regwrite → FETCH.
  - BEQ: A=10, B=00, aluop 01, resultsrc 00, branch → FETCH.
  - JAL: A=01, B=10, aluop 00, resultsrc 00, pcupdate → ALUWB.
- `pcwrite = pcupdate | (branch & zero)`.
- ALU decode, aluop 10: funct3 000 → sub if `op[5] & funct7b5`, else add; 010 slt; 110 or; 111 and; other funct3 → add plus `illegal` pulse in that execute state.
- `immsrc` combinational from `op`: lw/I-type I, sw S, beq B, jal J, lui U, else 000.

## Timing
- Moore outputs from state; `alucontrol`, `immsrc` combinational from state + instr fields; `pcwrite` combinational on `zero` in BEQ.
- Instruction cycles: lw 5, sw 4, R 4, I 4, lui 4, jal 4, beq 3, illegal 2.
- Reset asserted mid-instruction: immediate return to FETCH, in-flight writes dropped; first FETCH begins on first rising edge after deassertion.
- `op` only sampled in DECODE/MEMADR/EXECUTE; changes elsewhere ignored.

## Structure
- `riscv_pkg`: state enum, opcode constants, aluop, alucontrol, immsrc, srca/srcb/resultsrc encodings; shared with ALU and datapath.
- One sub-module: `alu_decoder` (aluop, funct3, funct7b5, op[5] → alucontrol, illegal).

## Test plan
- Reset low mid-MEMREAD → state FETCH, all enables 0; release → FETCH outputs irwrite=1, pcwrite=1, alucontrol=010.
- lw (op 0000011): FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 only in cycle 5 with resultsrc=01.
- R sub (op 0110011, f3 000, f7b5 1) → EXECUTER alucontrol=110; f3 111 → 000; f3 010 → 111.
- beq, zero=1 in BEQ → pcwrite=1; zero=0 → pcwrite=0; 3 cycles each.
- lui (op 0110111) → immsrc=100, EXECUTEI alucontrol=011, ALUWB regwrite=1.
- op 1111111 → `illegal` 1 cycle in DECODE, next state FETCH, no writes asserted.
